// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared constants, fetch FSM states and IF/ID record type.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    typedef enum logic [1:0] {
        BOOT = ST_BOOT,
        RUN  = ST_RUN,
        HALT = ST_HALT
    } fetch_state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
    } if_id_t;

    function automatic if_id_t if_id_bubble();
        if_id_t b;
        b.valid    = 1'b0;
        b.instr    = NOP_INSTR;
        b.pc       = 32'h0000_0000;
        b.pc_plus4 = 32'h0000_0000;
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage_if
// Description : Control, instruction-memory and IF/ID bundle of the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_stage_if;

    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [5:0]  id_opcode;
    logic [4:0]  id_branch_type;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic        fault;
    logic [31:0] fetch_count;

    modport master (
        input  stall, flush, redirect_valid, redirect_pc, imem_rdata,
        output imem_addr, id_valid, id_instr, id_opcode, id_branch_type,
               id_pc, id_pc_plus4, fault, fetch_count
    );

    modport slave (
        output stall, flush, redirect_valid, redirect_pc, imem_rdata,
        input  imem_addr, id_valid, id_instr, id_opcode, id_branch_type,
               id_pc, id_pc_plus4, fault, fetch_count
    );

endinterface
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_reg
// Description : IF/ID pipeline register with load, bubble and hold controls.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_reg
    import cpu_pkg::*;
(
    input  wire logic   clk,
    input  wire logic   rst,
    input  wire logic   load,
    input  wire logic   bubble,
    input  wire if_id_t d,
    output if_id_t      q
);

    if_id_t r_q;

    // Bubble beats load; neither asserted means hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= if_id_bubble();
        end else if (bubble) begin
            r_q <= if_id_bubble();
        end else if (load) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction fetch: PC, boot/run/halt control, IF/ID register.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import cpu_pkg::*;
(
    input  wire logic     clk,
    input  wire logic     rst,
    fetch_stage_if.master bus
);

    fetch_state_t r_state;
    fetch_state_t w_state_next;

    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic [31:0] w_pc_plus4;
    logic        r_fault;
    logic        w_fault_set;
    logic [31:0] r_fetch_count;
    logic        w_count_inc;
    logic        w_load;
    logic        w_bubble;
    if_id_t      w_if_id_d;
    if_id_t      w_if_id_q;

    assign w_pc_plus4 = r_pc + 32'd4;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_load       = 1'b0;
        w_bubble     = 1'b0;
        w_fault_set  = 1'b0;
        w_count_inc  = 1'b0;
        case (r_state)
            BOOT: begin
                w_bubble     = 1'b1;
                w_state_next = RUN;
            end
            RUN: begin
                if (bus.redirect_valid) begin
                    w_bubble = 1'b1;
                    // A misaligned target is unrecoverable without a reset.
                    if (bus.redirect_pc[1:0] == 2'b00) begin
                        w_pc_next = bus.redirect_pc;
                    end else begin
                        w_fault_set  = 1'b1;
                        w_state_next = HALT;
                    end
                end else if (bus.flush) begin
                    w_bubble  = 1'b1;
                    w_pc_next = bus.stall ? r_pc : w_pc_plus4;
                end else if (!bus.stall) begin
                    w_load      = 1'b1;
                    w_pc_next   = w_pc_plus4;
                    w_count_inc = 1'b1;
                end
            end
            HALT: begin
                w_bubble = 1'b1;
            end
            default: begin
                w_bubble     = 1'b1;
                w_state_next = HALT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_VECTOR;
            r_fault       <= 1'b0;
            r_fetch_count <= 32'd0;
        end else begin
            r_pc <= w_pc_next;
            if (w_fault_set) begin
                r_fault <= 1'b1;
            end
            if (w_count_inc) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
        end
    end

    always_comb begin
        w_if_id_d.valid    = 1'b1;
        w_if_id_d.instr    = bus.imem_rdata;
        w_if_id_d.pc       = r_pc;
        w_if_id_d.pc_plus4 = w_pc_plus4;
    end

    if_id_reg u_if_id_reg (
        .clk    (clk),
        .rst    (rst),
        .load   (w_load),
        .bubble (w_bubble),
        .d      (w_if_id_d),
        .q      (w_if_id_q)
    );

    assign bus.imem_addr      = r_pc;
    assign bus.id_valid       = w_if_id_q.valid;
    assign bus.id_instr       = w_if_id_q.instr;
    assign bus.id_opcode      = w_if_id_q.instr[31:26];
    assign bus.id_branch_type = w_if_id_q.instr[20:16];
    assign bus.id_pc          = w_if_id_q.pc;
    assign bus.id_pc_plus4    = w_if_id_q.pc_plus4;
    assign bus.fault          = r_fault;
    assign bus.fetch_count    = r_fetch_count;

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port stall, input, 1, hold PC and IF/ID contents this cycle.
REQ-004 SHALL have port flush, input, 1, load a bubble into IF/ID this cycle.
REQ-005 SHALL have port redirect_valid, input, 1, branch/jump taken; PC takes redirect_pc.
REQ-006 SHALL have port redirect_pc, input, 32, redirect target address.
REQ-007 SHALL have port imem_addr, output, 32, instruction memory address, equal to PC.
REQ-008 SHALL have port imem_rdata, input, 32, instruction word, combinational read of imem_addr in the same cycle.
REQ-009 SHALL have port id_valid, output, 1, IF/ID holds a real instruction.
REQ-010 SHALL have port id_instr, output, 32, registered instruction word.
REQ-011 SHALL have port id_opcode, output, 6, id_instr[31:26], consumed by the control decoder opcode input.
REQ-012 SHALL have port id_branch_type, output, 5, id_instr[20:16], consumed by the control decoder branch_type input.
REQ-013 SHALL have port id_pc, output, 32, address of id_instr.
REQ-014 SHALL have port id_pc_plus4, output, 32, id_pc+4, used for link writes.
REQ-015 SHALL have port fault, output, 1, sticky misaligned-redirect flag.
REQ-016 SHALL have port fetch_count, output, 32, number of instructions loaded into IF/ID with id_valid=1.

Function
REQ-017 SHALL implement FSM states BOOT, RUN, HALT.
REQ-018 BOOT: exactly one cycle after rst deasserts; PC held, IF/ID stays a bubble; next state RUN unconditionally (stall, flush and redirect ignored).
REQ-019 RUN, priority redirect > flush > stall > normal, evaluated each cycle.
REQ-020 Normal (no stall/flush/redirect): IF/ID <= {valid=1, imem_rdata, PC, PC+4}; PC <= PC+4; fetch_count += 1.
REQ-021 stall only: PC, IF/ID, fetch_count unchanged.
REQ-022 flush without redirect: IF/ID <= bubble; PC <= PC if stall else PC+4; fetch_count unchanged.
REQ-023 redirect_valid with redirect_pc[1:0]==0: PC <= redirect_pc and IF/ID <= bubble regardless of stall and flush.
REQ-024 redirect_valid with redirect_pc[1:0]!=0: PC held, IF/ID <= bubble, fault <= 1, next state HALT.
REQ-025 Bubble = id_valid 0, id_instr 32'h0000_0000 (NOP), id_pc and id_pc_plus4 0.
REQ-026 HALT: absorbing until rst; PC held, IF/ID bubble, fault 1, all inputs ignored.
REQ-027 PC+4 and fetch_count SHALL wrap modulo 2^32 with no flag.
REQ-028 Latency: instruction at PC appears on id_instr one clock after PC is presented on imem_addr.
REQ-029 id_opcode and id_branch_type SHALL be pure slices of the id_instr register, with no extra delay.

Reset
REQ-030 On rst: PC = RESET_VECTOR (32'hBFC0_0000); IF/ID = bubble; fault 0; fetch_count 0; state BOOT.
REQ-031 rst asserted mid-operation SHALL override every other input in the same clock edge, including redirect.

Structure
REQ-032 SHALL place RESET_VECTOR, NOP_INSTR, the FSM state enum and the IF/ID record typedef in a shared package cpu_pkg.
REQ-033 SHALL use one sub-module, if_id_reg, for the IF/ID register with load/bubble/hold controls; PC, FSM and counter stay in fetch_stage.

Verification
REQ-034 Reset, then imem returns 32'h2409_0005 at 0xBFC00000 -> BOOT cycle has id_valid 0; next edge id_valid 1, id_opcode 6'b001001, id_pc 0xBFC00000, id_pc_plus4 0xBFC00004, fetch_count 1.
REQ-035 stall held 3 cycles in RUN at PC 0xBFC00008 -> imem_addr stays 0xBFC00008, id_* unchanged, fetch_count unchanged; release -> fetching resumes at 0xBFC00008.
REQ-036 redirect_valid with redirect_pc 0xBFC00100 together with stall=1 and flush=1 -> next cycle imem_addr 0xBFC00100, id_valid 0; following cycle id_pc 0xBFC00100.
REQ-037 redirect_pc 0xBFC00102 -> fault 1, state HALT, imem_addr frozen; later redirects ignored; rst clears fault and returns PC to 0xBFC00000.
REQ-038 PC forced via redirect to 0xFFFF_FFFC, normal fetch -> next imem_addr 0x0000_0000, id_pc_plus4 0x0000_0000.
REQ-039 rst asserted in the same cycle as redirect_valid -> PC 0xBFC00000, state BOOT, fetch_count 0.
